// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_level stream buffer.
// Operation encoding is {push, pop}; count/hwm need one bit more than the pointers.
package fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_NONE = 2'b00,
        FIFO_R    = 2'b01,
        FIFO_W    = 2'b10,
        FIFO_WR   = 2'b11
    } fifo_op_e;

    // Occupancy spans 0..2**depth_w inclusive, so it needs depth_w+1 bits.
    function automatic int unsigned count_width(input int unsigned depth_w);
        return depth_w + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_level: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_level.sv
// Single-clock ready/valid FIFO with occupancy, almost-full/empty flags, flush and a
// high-water-mark monitor. Pointers wrap naturally; count disambiguates full from empty.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_W    = 5,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned ALMOST_FULL_TH  = 28,
    parameter int unsigned ALMOST_EMPTY_TH = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [DATA_W-1:0]                        a_data,
    input  logic                                     a_valid,
    output logic                                     a_ready,
    output logic [DATA_W-1:0]                        b_data,
    output logic                                     b_valid,
    input  logic                                     b_ready,
    input  logic                                     flush,
    input  logic                                     hwm_clr,
    output logic [count_width(FIFO_DEPTH_W)-1:0]     count,
    output logic                                     almost_full,
    output logic                                     almost_empty,
    output logic [count_width(FIFO_DEPTH_W)-1:0]     hwm
);

    localparam int unsigned CNT_W = count_width(FIFO_DEPTH_W);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_TH   = CNT_W'(ALMOST_EMPTY_TH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [FIFO_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        hwm_q, hwm_d;
    logic [CNT_W-1:0]        hwm_base;
    logic                    full, empty;
    logic                    push, pop;
    fifo_op_e                op;

    // Handshake qualification.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign a_ready = ~full & ~flush;
    assign b_valid = ~empty & ~flush;
    assign push    = a_valid & a_ready;
    assign pop     = b_valid & b_ready;
    assign op      = fifo_op_e'({push, pop});

    fifo_mem #(
        .ADDR_W (FIFO_DEPTH_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (a_data),
        .raddr (rd_ptr_q),
        .rdata (b_data)
    );

    always_comb begin
        count_d = count_q;
        unique case (op)
            FIFO_W:    count_d = count_q + ONE_C;
            FIFO_R:    count_d = count_q - ONE_C;
            FIFO_WR:   count_d = count_q;
            FIFO_NONE: count_d = count_q;
            default:   count_d = count_q;
        endcase
        if (flush) begin
            count_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Clearing and flushing in the same cycle leaves hwm at zero.
    always_comb begin
        hwm_base = hwm_clr ? '0 : hwm_q;
        hwm_d    = (count_d > hwm_base) ? count_d : hwm_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    assign count        = count_q;
    assign hwm          = hwm_q;
    assign almost_full  = (count_q >= AF_TH);
    assign almost_empty = (count_q <= AE_TH);

    // Full and empty both leave the pointers equal, so the low count bits track the difference.
    logic [FIFO_DEPTH_W-1:0] ptr_diff;
    assign ptr_diff = wr_ptr_q - rd_ptr_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        (count_q <= DEPTH_C) && (count_q[FIFO_DEPTH_W-1:0] == ptr_diff));

endmodule

// File: tb/tb_fifo_level.sv
// Directed and randomized bench for fifo_level (DEPTH=4) against a queue-based model.
module tb_fifo_level;

    localparam int unsigned DEPTH_W = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned AF      = 3;
    localparam int unsigned AE      = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       flush;
    logic       hwm_clr;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] hwm;

    int checks = 0;
    int errors = 0;

    byte unsigned q[$];
    int           hwm_m;

    fifo_level #(
        .FIFO_DEPTH_W    (DEPTH_W),
        .DATA_W          (8),
        .ALMOST_FULL_TH  (AF),
        .ALMOST_EMPTY_TH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_data       (a_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b_data       (b_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .flush        (flush),
        .hwm_clr      (hwm_clr),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .hwm          (hwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("hwm", 32'(hwm), 32'(hwm_m));
        chk("a_ready", 32'(a_ready), 32'((n != DEPTH) && !flush));
        chk("b_valid", 32'(b_valid), 32'((n != 0) && !flush));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        if (n != 0 && !flush) begin
            chk("b_data", 32'(b_data), 32'(q[0]));
        end
    endtask

    // Check outputs against the model, clock once, then advance the model.
    task automatic cycle();
        bit         do_push, do_pop;
        int         base;
        int         n;
        logic [7:0] d;
        #1;
        check_model();
        do_push = a_valid && (q.size() != DEPTH) && !flush;
        do_pop  = b_ready && (q.size() != 0) && !flush;
        d       = a_data;
        @(posedge clk);
        if (rst) begin
            q.delete();
            hwm_m = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
            if (flush) q.delete();
            base  = hwm_clr ? 0 : hwm_m;
            n     = q.size();
            hwm_m = (n > base) ? n : base;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; a_data = '0; a_valid = 1'b0; b_ready = 1'b0; flush = 1'b0; hwm_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        hwm_m = 0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_hwm", 32'(hwm), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);

        // Fill to full, then try a fifth write.
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'(8'h11 * (i + 1));
            cycle();
            chk("t1_count", 32'(count), 32'(i + 1));
            chk("t1_almost_full", 32'(almost_full), 32'(i >= 2));
        end
        chk("t1_a_ready_full", 32'(a_ready), 32'd0);
        a_data = 8'h55;
        cycle();
        chk("t1_count_after_5th", 32'(count), 32'd4);
        chk("t1_hwm", 32'(hwm), 32'd4);

        // Drain in order.
        a_valid = 1'b0;
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_b_data", 32'(b_data), 32'(8'h11 * (i + 1)));
            chk("t2_almost_empty", 32'(almost_empty), 32'(i >= 3));
            cycle();
        end
        chk("t2_b_valid_empty", 32'(b_valid), 32'd0);
        chk("t2_almost_empty_end", 32'(almost_empty), 32'd1);

        // Steady streaming at count=2 across two pointer wraps.
        b_ready = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'hA0;
        cycle();
        a_data  = 8'hA1;
        cycle();
        b_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a_data = 8'(8'hA2 + k);
            #1;
            chk("t3_b_data", 32'(b_data), 32'(8'hA0 + k));
            cycle();
            chk("t3_count", 32'(count), 32'd2);
        end

        // Empty FIFO with both sides active: push only.
        a_valid = 1'b0;
        cycle();
        cycle();
        a_valid = 1'b1;
        a_data  = 8'h5A;
        #1;
        chk("t4_b_valid_empty", 32'(b_valid), 32'd0);
        cycle();
        chk("t4_count", 32'(count), 32'd1);
        a_valid = 1'b0;
        b_ready = 1'b0;
        #1;
        chk("t4_b_data", 32'(b_data), 32'h5A);

        // Restart hwm, fill to 3, then flush.
        hwm_clr = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'h61;
        cycle();
        chk("t5_hwm_clr", 32'(hwm), 32'd2);
        hwm_clr = 1'b0;
        a_data  = 8'h62;
        cycle();
        chk("t5_count3", 32'(count), 32'd3);
        flush   = 1'b1;
        b_ready = 1'b1;
        #1;
        chk("t5_flush_a_ready", 32'(a_ready), 32'd0);
        chk("t5_flush_b_valid", 32'(b_valid), 32'd0);
        cycle();
        flush   = 1'b0;
        a_valid = 1'b0;
        b_ready = 1'b0;
        #1;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_b_valid", 32'(b_valid), 32'd0);
        chk("t5_a_ready", 32'(a_ready), 32'd1);
        chk("t5_hwm", 32'(hwm), 32'd3);

        // hwm_clr with a push at count=2 after hwm=4.
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'(8'h70 + i);
            cycle();
        end
        a_valid = 1'b0;
        b_ready = 1'b1;
        cycle();
        cycle();
        chk("t6_count2", 32'(count), 32'd2);
        chk("t6_hwm4", 32'(hwm), 32'd4);
        b_ready = 1'b0;
        a_valid = 1'b1;
        hwm_clr = 1'b1;
        a_data  = 8'h80;
        cycle();
        hwm_clr = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("t6_hwm_after_clr", 32'(hwm), 32'd3);
        chk("t6_count3", 32'(count), 32'd3);
        rst   = 1'b1;
        flush = 1'b1;
        cycle();
        rst   = 1'b0;
        flush = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_hwm", 32'(hwm), 32'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
            a_data  = 8'($urandom);
            flush   = ($urandom_range(0, 15) == 0);
            hwm_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst     = 1'b0;
        flush   = 1'b0;
        hwm_clr = 1'b0;
        a_valid = 1'b0;
        b_ready = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
